t03_load_store_unit: RTL
========================

Name: t03_load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU: takes the ALU result as the effective address and rs2 as store data.
- Runs a single data-bus transaction per load/store, and stalls the core (freeze) until the transaction completes.
- Performs RV32I byte/half/word lane steering and sign/zero extension; returns load data to writeback.

Parameters:
TIMEOUT_CYCLES, 255, ack wait limit in cycles (used only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
mem_read  in  1  current instruction is a load
mem_write  in  1  current instruction is a store
funct3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
alu_result  in  32  effective byte address from ALU
store_data  in  32  rs2 value
bus_ack  in  1  bus completes transaction this cycle
bus_rdata  in  32  read data, valid when bus_ack=1
bus_read  out  1  read request
bus_write  out  1  write request
bus_addr  out  32  word address {alu_result[31:2],2'b00}, registered
bus_wdata  out  32  lane-replicated store data, registered
bus_sel  out  4  byte enables, registered
load_data  out  32  extended load result, held until next load completes
freeze  out  1  stall PC/pipeline while high
access_fault  out  1  one-cycle pulse: misaligned, illegal funct3, or read&write both high
bus_error  out  1  one-cycle pulse on timeout (LSU_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0, including load_data, bus_addr, bus_wdata and bus_sel. Any in-flight bus transaction is abandoned.
- States: IDLE, REQ, DONE.
- IDLE, with mem_read^mem_write and a legal aligned access:
  - freeze=1 combinationally.
  - Register bus_addr, bus_sel and bus_wdata.
  - Next state REQ.
- IDLE, with a fault:
  - Fault conditions: mem_read&mem_write; funct3 not listed for the op (stores accept only 000/001/010); H/HU with addr[0]=1; W with addr[1:0]!=0.
  - access_fault=1 registered (pulses next cycle for one cycle), freeze=0, no bus access.
  - Stay in IDLE; load_data unchanged.
- IDLE, with neither mem_read nor mem_write: freeze=0, no action.
- REQ:
  - bus_read or bus_write held high, freeze=1; bus_addr/bus_sel/bus_wdata stable.
  - On bus_ack=1: a load captures the extended bus_rdata into load_data; next state DONE.
  - bus_ack sampled only in REQ; acks in other states are ignored.
- DONE:
  - bus_read=bus_write=0, freeze=0 (core advances at the end of this cycle).
  - Next state IDLE unconditionally, so the same instruction is not re-issued.
- Minimum access latency: 3 cycles (IDLE, REQ with immediate ack, DONE). Each extra ack wait cycle adds 1.
- Byte lane steering, with o=alu_result[1:0]:
  - SB: bus_sel=4'b0001<<o, bus_wdata={4{store_data[7:0]}}.
  - SH: bus_sel=4'b0011<<o, bus_wdata={2{store_data[15:0]}}.
  - SW: bus_sel=4'b1111, bus_wdata=store_data.
  - Loads drive bus_sel with the same pattern as the equivalent store width.
- Load extraction: shifted=bus_rdata>>(8*o).
  - B: sign-extend shifted[7:0]. BU: zero-extend shifted[7:0].
  - H: sign-extend shifted[15:0]. HU: zero-extend shifted[15:0].
  - W: bus_rdata unchanged.
- Stores never modify load_data.
- mem_read/mem_write/funct3/alu_result changing while in REQ: ignored, because request fields were registered in IDLE.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to REQ and increments each REQ cycle without ack.
  - On reaching TIMEOUT_CYCLES, abort: bus_error pulses 1 cycle, load_data=0 for loads, next state DONE.
  - An ack arriving on the same cycle as the limit wins; bus_error stays 0.
- Undefined: no counter; REQ waits indefinitely; bus_error tied 0.

Test Plan:
- LW at 0x0000_1004, bus_rdata=0xDEAD_BEEF, ack on first REQ cycle:
  - bus_addr=0x1004, bus_sel=1111, freeze high 2 cycles.
  - load_data=0xDEADBEEF in DONE.
- LB / LBU at 0x1003, bus_rdata=0x80FF_0000:
  - bus_sel=1000.
  - LB gives load_data=0xFFFFFF80; LBU gives 0x00000080.
- SH at 0x2002, store_data=0x1234_ABCD:
  - bus_write=1, bus_sel=1100, bus_wdata=0xABCDABCD, bus_addr=0x2000.
  - load_data unchanged.
- LW at 0x3001 (misaligned), then mem_read&mem_write both high:
  - Each gives access_fault one-cycle pulse, bus_read/bus_write never high, freeze=0.
- LH with ack delayed 5 cycles, rst pulsed during the 3rd REQ cycle:
  - Outputs immediately 0, state IDLE.
  - A later ack is ignored; a new LH completes normally.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack:
  - bus_error pulses after 4 REQ cycles, load_data=0, freeze drops in DONE.
  - Ack on exactly cycle 4 gives normal completion, bus_error=0.

Source files
------------

// File: rtl/t03_load_store_unit.sv
// t03_load_store_unit: RV32I memory-access stage.
// Issues one data-bus transaction per load/store, freezes the core until it
// completes, steers byte lanes and sign/zero-extends load results.
// Optional ack timeout: define LSU_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module t03_load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic [31:0] load_data,
  output logic        freeze,
  output logic        access_fault,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_bus_read;
  logic        r_bus_write;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_sel;
  logic [31:0] r_load_data;
  logic        r_access_fault;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;

  logic        w_single;
  logic        w_both;
  logic        w_f3_ok;
  logic        w_align_ok;
  logic        w_start;
  logic        w_fault;
  logic [1:0]  w_off;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;

`ifdef LSU_TIMEOUT_EN
  logic [31:0] r_tcnt;
  logic        r_bus_error;
  logic        w_tmo;

  assign w_tmo     = (r_tcnt == (TIMEOUT_CYCLES - 32'd1));
  assign bus_error = r_bus_error;
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign bus_error        = 1'b0;
`endif

  assign w_off = alu_result[1:0];

  // Request decode: legality of funct3 for the op and natural alignment
  always_comb begin
    w_single   = mem_read ^ mem_write;
    w_both     = mem_read & mem_write;
    w_f3_ok    = 1'b0;
    w_align_ok = 1'b0;
    case (funct3)
      3'b000: begin
        w_f3_ok    = 1'b1;
        w_align_ok = 1'b1;
      end
      3'b001: begin
        w_f3_ok    = 1'b1;
        w_align_ok = ~alu_result[0];
      end
      3'b010: begin
        w_f3_ok    = 1'b1;
        w_align_ok = (w_off == 2'b00);
      end
      3'b100: begin
        w_f3_ok    = mem_read;
        w_align_ok = 1'b1;
      end
      3'b101: begin
        w_f3_ok    = mem_read;
        w_align_ok = ~alu_result[0];
      end
      default: begin
        w_f3_ok    = 1'b0;
        w_align_ok = 1'b0;
      end
    endcase
    w_start = w_single & w_f3_ok & w_align_ok;
    w_fault = w_both | (w_single & ~(w_f3_ok & w_align_ok));
  end

  // Byte-enable and store-data lane replication by access width
  always_comb begin
    w_sel   = 4'b1111;
    w_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        w_sel   = 4'b0001 << w_off;
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_sel   = 4'b0011 << w_off;
        w_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_sel   = 4'b1111;
        w_wdata = store_data;
      end
    endcase
  end

  // Load lane extraction and extension from the registered offset/width.
  // Halfword loads are always even-aligned here, so r_off[1] picks the half.
  always_comb begin
    w_byte     = bus_rdata[7:0];
    case (r_off)
      2'd0:    w_byte = bus_rdata[7:0];
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      default: w_byte = bus_rdata[31:24];
    endcase
    w_half     = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    w_load_ext = bus_rdata;
    case (r_f3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_ext = {24'd0, w_byte};
      3'b101:  w_load_ext = {16'd0, w_half};
      default: w_load_ext = bus_rdata;
    endcase
  end

  // Access FSM with registered bus request, fault/error pulses and load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_bus_read     <= 1'b0;
      r_bus_write    <= 1'b0;
      r_bus_addr     <= '0;
      r_bus_wdata    <= '0;
      r_bus_sel      <= '0;
      r_load_data    <= '0;
      r_access_fault <= 1'b0;
      r_off          <= '0;
      r_f3           <= '0;
`ifdef LSU_TIMEOUT_EN
      r_tcnt         <= '0;
      r_bus_error    <= 1'b0;
`endif
    end else begin
      r_access_fault <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_bus_error    <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_bus_addr  <= {alu_result[31:2], 2'b00};
            r_bus_sel   <= w_sel;
            r_bus_wdata <= w_wdata;
            r_bus_read  <= mem_read;
            r_bus_write <= mem_write;
            r_off       <= w_off;
            r_f3        <= funct3;
`ifdef LSU_TIMEOUT_EN
            r_tcnt      <= '0;
`endif
            r_state     <= S_REQ;
          end else if (w_fault) begin
            r_access_fault <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            if (r_bus_read) begin
              r_load_data <= w_load_ext;
            end
            r_bus_read  <= 1'b0;
            r_bus_write <= 1'b0;
            r_state     <= S_DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (w_tmo) begin
            r_bus_error <= 1'b1;
            if (r_bus_read) begin
              r_load_data <= '0;
            end
            r_bus_read  <= 1'b0;
            r_bus_write <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_tcnt <= r_tcnt + 32'd1;
          end
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_read     = r_bus_read;
  assign bus_write    = r_bus_write;
  assign bus_addr     = r_bus_addr;
  assign bus_wdata    = r_bus_wdata;
  assign bus_sel      = r_bus_sel;
  assign load_data    = r_load_data;
  assign access_fault = r_access_fault;
  // Freeze is combinational in IDLE so the core stalls on the issuing cycle
  assign freeze       = ~rst & (((r_state == S_IDLE) & w_start) | (r_state == S_REQ));

endmodule
